vga_bus_fifo: RTL and testbench

- Upstream stage of the VGA controller: captures 6502 register writes (REG/DATA while EN and RW are low) and queues them for the framebuffer/register command engine.
- Runs entirely in the CLK_FAST domain. CLK_CPU, EN, RW, REG and DATA are treated as asynchronous inputs and synchronised inside the block.
- Each accepted bus write becomes one 11-bit command {reg[2:0], data[7:0]}, delivered through a first-word-fall-through FIFO with a valid/ready handshake.
- Overflow is reported rather than hidden.

---
 rtl/vga_bus_fifo.sv | 118 +++++++++++
 tb/tb_vga_bus_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_bus_fifo.sv
// 6502 bus write capture for the VGA controller: synchronises the async bus,
// detects phi2 falling edges on selected writes, and queues {reg,data} in a FWFT FIFO.
module vga_bus_fifo #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_FAST,
  input  logic              RESET,
  input  logic              CLK_CPU,
  input  logic              EN,
  input  logic              RW,
  input  logic [2:0]        REG,
  input  logic [7:0]        DATA,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  input  logic              ovf_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [SYNC_STAGES-1:0] cpu_s, en_s, rw_s;
  logic [2:0]             reg_s  [SYNC_STAGES];
  logic [7:0]             data_s [SYNC_STAGES];

  logic       cpu_h, en_h, rw_h;
  logic [2:0] reg_h;
  logic [7:0] data_h;

  logic [ADDR_W:0] wptr, rptr;
  logic [10:0]     mem [DEPTH];
  logic [10:0]     head;
  logic            detect, push, pop, drop;
  logic            ovf_q;
  logic [7:0]      drop_q;

  // Synchroniser chains followed by the hold stage; reset loads bus-idle values.
  always_ff @(posedge CLK_FAST) begin
    if (!RESET) begin
      cpu_s  <= '0;
      en_s   <= '1;
      rw_s   <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        reg_s[i]  <= '0;
        data_s[i] <= '0;
      end
      cpu_h  <= 1'b0;
      en_h   <= 1'b1;
      rw_h   <= 1'b1;
      reg_h  <= '0;
      data_h <= '0;
    end else begin
      cpu_s     <= {cpu_s[SYNC_STAGES-2:0], CLK_CPU};
      en_s      <= {en_s[SYNC_STAGES-2:0], EN};
      rw_s      <= {rw_s[SYNC_STAGES-2:0], RW};
      reg_s[0]  <= REG;
      data_s[0] <= DATA;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        reg_s[i]  <= reg_s[i-1];
        data_s[i] <= data_s[i-1];
      end
      cpu_h  <= cpu_s[SYNC_STAGES-1];
      en_h   <= en_s[SYNC_STAGES-1];
      rw_h   <= rw_s[SYNC_STAGES-1];
      reg_h  <= reg_s[SYNC_STAGES-1];
      data_h <= data_s[SYNC_STAGES-1];
    end
  end

  assign fifo_count = wptr - rptr;
  assign fifo_full  = (fifo_count == FULL_CNT);
  assign cmd_valid  = (fifo_count != '0);

  // Hold stage still reflects phi2-high values in the cycle the falling edge is seen.
  assign detect = cpu_h & ~cpu_s[SYNC_STAGES-1] & ~en_h & ~rw_h;
  assign pop    = cmd_valid & cmd_ready;
  assign push   = detect & (~fifo_full | pop);
  assign drop   = detect & fifo_full & ~pop;

  always_ff @(posedge CLK_FAST) begin
    if (!RESET) begin
      wptr   <= '0;
      rptr   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_clr)
          drop_q <= 8'd1;
        else if (drop_q != '1)
          drop_q <= drop_q + 8'd1;
      end else if (ovf_clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK_FAST) begin
    if (push) mem[wptr[ADDR_W-1:0]] <= {reg_h, data_h};
  end

  assign head     = mem[rptr[ADDR_W-1:0]];
  assign cmd_reg  = cmd_valid ? head[10:8] : '0;
  assign cmd_data = cmd_valid ? head[7:0]  : '0;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_bus_fifo.sv
// Directed bench for vga_bus_fifo: drives phi2 bus cycles and checks the queued commands.
module tb_vga_bus_fifo;

  logic       CLK_FAST = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK_CPU = 1'b0;
  logic       EN = 1'b1;
  logic       RW = 1'b1;
  logic [2:0] REG = '0;
  logic [7:0] DATA = '0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_reg;
  logic [7:0] cmd_data;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  vga_bus_fifo #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .CLK_FAST(CLK_FAST), .RESET(RESET), .CLK_CPU(CLK_CPU), .EN(EN), .RW(RW),
    .REG(REG), .DATA(DATA), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .overflow(overflow), .drop_cnt(drop_cnt),
    .ovf_clr(ovf_clr)
  );

  always #5 CLK_FAST = ~CLK_FAST;

  task automatic tick();
    @(posedge CLK_FAST);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One phi2 cycle; rdy/clr are raised for the single cycle in which the write is detected.
  task automatic bus_cycle(input logic en, input logic rw, input logic [2:0] r,
                           input logic [7:0] d, input logic rdy, input logic clr);
    tick();
    EN = en; RW = rw; REG = r; DATA = d; CLK_CPU = 1'b1;
    repeat (4) tick();
    CLK_CPU = 1'b0;
    tick();
    tick();
    cmd_ready = rdy; ovf_clr = clr;
    tick();
    cmd_ready = 1'b0; ovf_clr = 1'b0; EN = 1'b1; RW = 1'b1;
    tick();
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) bus_cycle(1'b0, 1'b0, 3'd2, base + 8'(i), 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_reg", 32'(cmd_reg), 0);
    chk("rst_data", 32'(cmd_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    RESET = 1'b1;
    repeat (2) tick();

    // Single write and its latency from the first edge seeing phi2 low
    EN = 1'b0; RW = 1'b0; REG = 3'd3; DATA = 8'h41; CLK_CPU = 1'b1;
    repeat (4) tick();
    CLK_CPU = 1'b0;
    tick();
    tick();
    chk("lat_edge2_valid", 32'(cmd_valid), 0);
    tick();
    chk("lat_edge3_valid", 32'(cmd_valid), 1);
    chk("single_reg", 32'(cmd_reg), 3);
    chk("single_data", 32'(cmd_data), 32'h41);
    chk("single_count", 32'(fifo_count), 1);
    EN = 1'b1; RW = 1'b1;
    repeat (3) tick();
    chk("single_stable", 32'(cmd_data), 32'h41);
    pop_one();
    chk("single_pop_valid", 32'(cmd_valid), 0);
    chk("single_pop_count", 32'(fifo_count), 0);

    // Read cycle and deselected write are ignored
    bus_cycle(1'b0, 1'b1, 3'd5, 8'h77, 1'b0, 1'b0);
    bus_cycle(1'b1, 1'b0, 3'd6, 8'h88, 1'b0, 1'b0);
    repeat (3) tick();
    chk("ignore_valid", 32'(cmd_valid), 0);
    chk("ignore_count", 32'(fifo_count), 0);

    // Fill, overflow on the 17th, drain in order
    fill16(8'h00);
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_count", 32'(fifo_count), 16);
    chk("fill_ovf", 32'(overflow), 0);
    bus_cycle(1'b0, 1'b0, 3'd2, 8'h10, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_cnt1", 32'(drop_cnt), 1);
    chk("drop_count", 32'(fifo_count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(cmd_valid), 1);
      chk("drain_reg", 32'(cmd_reg), 2);
      chk("drain_data", 32'(cmd_data), 32'(i));
      pop_one();
    end
    chk("drain_empty", 32'(cmd_valid), 0);
    chk("drain_count", 32'(fifo_count), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_cnt), 0);

    // Full FIFO: write accepted when a pop lands in the same cycle
    fill16(8'h20);
    bus_cycle(1'b0, 1'b0, 3'd4, 8'h55, 1'b1, 1'b0);
    chk("pushpop_count", 32'(fifo_count), 16);
    chk("pushpop_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      chk("pushpop_data", 32'(cmd_data), 32'h20 + 32'(i));
      pop_one();
    end
    chk("pushpop_last_reg", 32'(cmd_reg), 4);
    chk("pushpop_last_data", 32'(cmd_data), 32'h55);
    pop_one();
    chk("pushpop_empty", 32'(fifo_count), 0);

    // Streaming with cmd_ready held high; pointers wrap during this run
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      EN = 1'b0; RW = 1'b0; REG = 3'(i); DATA = 8'h80 + 8'(i); CLK_CPU = 1'b1;
      repeat (4) tick();
      CLK_CPU = 1'b0;
      tick();
      tick();
      chk("stream_pre_count", 32'(fifo_count), 0);
      tick();
      chk("stream_valid", 32'(cmd_valid), 1);
      chk("stream_data", 32'(cmd_data), 32'h80 + 32'(i));
      chk("stream_reg", 32'(cmd_reg), 32'(i % 8));
      chk("stream_count", 32'(fifo_count), 1);
      EN = 1'b1; RW = 1'b1;
      tick();
      chk("stream_gone", 32'(cmd_valid), 0);
    end
    cmd_ready = 1'b0;

    // Mid-stream reset discards queued entries
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, 3'd7, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("pre_reset_count", 32'(fifo_count), 3);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    chk("mid_rst_valid", 32'(cmd_valid), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_data", 32'(cmd_data), 0);
    chk("mid_rst_full", 32'(fifo_full), 0);
    bus_cycle(1'b0, 1'b0, 3'd1, 8'h1F, 1'b0, 1'b0);
    chk("post_rst_count", 32'(fifo_count), 1);
    chk("post_rst_reg", 32'(cmd_reg), 1);
    chk("post_rst_data", 32'(cmd_data), 32'h1F);
    pop_one();
    chk("post_rst_empty", 32'(cmd_valid), 0);

    // Drop coinciding with ovf_clr, then saturation
    fill16(8'h60);
    bus_cycle(1'b0, 1'b0, 3'd0, 8'hEE, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b0, 3'd0, 8'hEE, 1'b0, 1'b0);
    chk("drop_cnt2", 32'(drop_cnt), 2);
    bus_cycle(1'b0, 1'b0, 3'd0, 8'hEE, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(overflow), 1);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);
    for (int i = 0; i < 255; i++) bus_cycle(1'b0, 1'b0, 3'd0, 8'hEE, 1'b0, 1'b0);
    chk("sat_cnt", 32'(drop_cnt), 255);
    chk("sat_count", 32'(fifo_count), 16);
    chk("sat_head", 32'(cmd_data), 32'h60);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("final_clr_ovf", 32'(overflow), 0);
    chk("final_clr_cnt", 32'(drop_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
